// File: rtl/ps2_key_decoder.sv
// PS/2 key-event decoder: maps scan codes to per-key level/press/release/auto-repeat outputs.
// Optional event latch (ev_* ports) is enabled by defining KEYDEC_EVENT_LATCH_EN.
module ps2_key_decoder #(
  parameter int unsigned                NUM_KEYS      = 16,
  parameter logic [NUM_KEYS*8-1:0]      KEY_CODES     = '0,
  parameter logic [NUM_KEYS*2-1:0]      KEY_MODES     = '0,
  parameter int unsigned                REPEAT_DELAY  = 25_000_000,
  parameter int unsigned                REPEAT_PERIOD = 4_194_304,
  parameter int unsigned                CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          ps2_byte,
  input  logic                ps2_state,
  output logic [NUM_KEYS-1:0] keys,
  output logic                any_key
`ifdef KEYDEC_EVENT_LATCH_EN
  ,
  output logic                ev_valid,
  output logic [7:0]          ev_code,
  input  logic                ev_ack,
  output logic                ev_overflow
`endif
);

  localparam int unsigned IdxW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_st_e;

  logic                state_s1_q, state_s2_q;
  logic [7:0]          byte_s1_q, byte_s2_q;
  logic [NUM_KEYS-1:0] match, rise, fall, rep_rise, rep_pulse;
  logic [NUM_KEYS-1:0] prev_match_q;
  logic [NUM_KEYS-1:0] keys_d, keys_q;
  logic                any_key_d, any_key_q;
  rep_st_e             rep_st_d, rep_st_q;
  logic [IdxW-1:0]     idx_d, idx_q, new_idx;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic                rep_hit;

  always_comb begin
    match    = '0;
    rep_rise = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      match[i] = state_s2_q && (byte_s2_q == KEY_CODES[8*i+:8]);
    end
    rise = match & ~prev_match_q;
    fall = ~match & prev_match_q;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      rep_rise[i] = rise[i] && (KEY_MODES[2*i+:2] == 2'b10);
    end
    rep_hit = |rep_rise;
    // Lowest-numbered rising repeat key wins if duplicates share a code.
    new_idx = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (rep_rise[i]) new_idx = IdxW'(i);
    end
  end

  // Shared typematic engine: only one scan code can be held at a time.
  always_comb begin
    rep_st_d  = rep_st_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rep_pulse = '0;
    if (rep_hit) begin
      rep_pulse[new_idx] = 1'b1;
      idx_d              = new_idx;
      cnt_d              = '0;
      rep_st_d           = StDelay;
    end else begin
      unique case (rep_st_q)
        StIdle: ;
        StDelay: begin
          if (!match[idx_q]) begin
            rep_st_d = StIdle;
            cnt_d    = '0;
          end else if (cnt_q == DelayLast) begin
            rep_pulse[idx_q] = 1'b1;
            cnt_d            = '0;
            rep_st_d         = StRepeat;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StRepeat: begin
          if (!match[idx_q]) begin
            rep_st_d = StIdle;
            cnt_d    = '0;
          end else if (cnt_q == PeriodLast) begin
            rep_pulse[idx_q] = 1'b1;
            cnt_d            = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: rep_st_d = StIdle;
      endcase
    end
  end

  always_comb begin
    keys_d = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      unique case (KEY_MODES[2*i+:2])
        2'b00: keys_d[i] = match[i];
        2'b01: keys_d[i] = rise[i];
        2'b10: keys_d[i] = rep_pulse[i];
        2'b11: keys_d[i] = fall[i];
        default: keys_d[i] = 1'b0;
      endcase
    end
    any_key_d = |match;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_s1_q   <= 1'b0;
      state_s2_q   <= 1'b0;
      byte_s1_q    <= '0;
      byte_s2_q    <= '0;
      prev_match_q <= '0;
      keys_q       <= '0;
      any_key_q    <= 1'b0;
      rep_st_q     <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_s1_q   <= ps2_state;
      state_s2_q   <= state_s1_q;
      byte_s1_q    <= ps2_byte;
      byte_s2_q    <= byte_s1_q;
      prev_match_q <= match;
      keys_q       <= keys_d;
      any_key_q    <= any_key_d;
      rep_st_q     <= rep_st_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
    end
  end

  assign keys    = keys_q;
  assign any_key = any_key_q;

`ifdef KEYDEC_EVENT_LATCH_EN
  logic       ev_valid_d, ev_valid_q;
  logic [7:0] ev_code_d, ev_code_q;
  logic       ev_overflow_d, ev_overflow_q;

  // An ack in the same cycle as a new press frees the slot for the new code.
  always_comb begin
    ev_valid_d    = ev_valid_q;
    ev_code_d     = ev_code_q;
    ev_overflow_d = ev_overflow_q;
    if (|rise) begin
      if (!ev_valid_q || ev_ack) begin
        ev_valid_d = 1'b1;
        ev_code_d  = byte_s2_q;
      end else begin
        ev_overflow_d = 1'b1;
      end
    end else if (ev_ack) begin
      ev_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid_q    <= 1'b0;
      ev_code_q     <= '0;
      ev_overflow_q <= 1'b0;
    end else begin
      ev_valid_q    <= ev_valid_d;
      ev_code_q     <= ev_code_d;
      ev_overflow_q <= ev_overflow_d;
    end
  end

  assign ev_valid    = ev_valid_q;
  assign ev_code     = ev_code_q;
  assign ev_overflow = ev_overflow_q;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: per-cycle vector table plus repeat/reset/event sequences.
// Event-latch checks run only when KEYDEC_EVENT_LATCH_EN is defined.
module tb_ps2_key_decoder;

  // key0 43 level, key1 1D press, key2 29 release, key3 75 repeat, key4 72 repeat, key5 1D level
  localparam int unsigned NK = 6;
  localparam logic [NK*8-1:0] Codes = {8'h1D, 8'h72, 8'h75, 8'h29, 8'h1D, 8'h43};
  localparam logic [NK*2-1:0] Modes = {2'b00, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00};

  logic          clk;
  logic          rst;
  logic [7:0]    ps2_byte;
  logic          ps2_state;
  logic [NK-1:0] keys;
  logic          any_key;
`ifdef KEYDEC_EVENT_LATCH_EN
  logic          ev_valid;
  logic [7:0]    ev_code;
  logic          ev_ack;
  logic          ev_overflow;
`endif

  int checks = 0;
  int errors = 0;

  ps2_key_decoder #(
    .NUM_KEYS     (NK),
    .KEY_CODES    (Codes),
    .KEY_MODES    (Modes),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(4),
    .CNT_W        (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_byte (ps2_byte),
    .ps2_state(ps2_state),
    .keys     (keys),
    .any_key  (any_key)
`ifdef KEYDEC_EVENT_LATCH_EN
    ,
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_ack     (ev_ack),
    .ev_overflow(ev_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [7:0] b;
    logic [5:0] ek;
    logic       ea;
  } vec_t;

  vec_t tbl [28];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample 1 time unit after the edge.
  task automatic step(input logic s, input logic [7:0] b, input logic r);
    ps2_state = s;
    ps2_byte  = b;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [5:0] exp_k;
    // Outputs at row j reflect inputs of row j-2 (3-cycle latency).
    tbl[0]  = '{1'b0, 8'h00, 6'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h43, 6'h00, 1'b0};
    tbl[2]  = '{1'b1, 8'h43, 6'h00, 1'b0};
    tbl[3]  = '{1'b1, 8'h43, 6'h01, 1'b1};
    tbl[4]  = '{1'b0, 8'h43, 6'h01, 1'b1};
    tbl[5]  = '{1'b0, 8'h43, 6'h01, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 6'h00, 1'b0};
    tbl[7]  = '{1'b1, 8'h1D, 6'h00, 1'b0};
    tbl[8]  = '{1'b1, 8'h1D, 6'h00, 1'b0};
    tbl[9]  = '{1'b1, 8'h1D, 6'h22, 1'b1};
    tbl[10] = '{1'b0, 8'h1D, 6'h20, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 6'h20, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 6'h00, 1'b0};
    tbl[13] = '{1'b1, 8'h29, 6'h00, 1'b0};
    tbl[14] = '{1'b1, 8'h29, 6'h00, 1'b0};
    tbl[15] = '{1'b0, 8'h29, 6'h00, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 6'h00, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 6'h04, 1'b0};
    tbl[18] = '{1'b0, 8'h00, 6'h00, 1'b0};
    tbl[19] = '{1'b1, 8'h43, 6'h00, 1'b0};
    tbl[20] = '{1'b1, 8'h1D, 6'h00, 1'b0};
    tbl[21] = '{1'b0, 8'h00, 6'h01, 1'b1};
    tbl[22] = '{1'b0, 8'h00, 6'h22, 1'b1};
    tbl[23] = '{1'b0, 8'h00, 6'h00, 1'b0};
    tbl[24] = '{1'b1, 8'hFF, 6'h00, 1'b0};
    tbl[25] = '{1'b1, 8'hFF, 6'h00, 1'b0};
    tbl[26] = '{1'b0, 8'h00, 6'h00, 1'b0};
    tbl[27] = '{1'b0, 8'h00, 6'h00, 1'b0};

    ps2_state = 1'b0;
    ps2_byte  = 8'h00;
    rst       = 1'b1;
`ifdef KEYDEC_EVENT_LATCH_EN
    ev_ack    = 1'b0;
`endif

    // Reset state.
    step(1'b1, 8'h43, 1'b1);
    step(1'b1, 8'h43, 1'b1);
    check("reset_keys", 32'(keys), 32'h0);
    check("reset_any", 32'(any_key), 32'h0);
`ifdef KEYDEC_EVENT_LATCH_EN
    check("reset_ev_valid", 32'(ev_valid), 32'h0);
    check("reset_ev_code", 32'(ev_code), 32'h0);
    check("reset_ev_overflow", 32'(ev_overflow), 32'h0);
`endif
    do_reset();

    // Level, press, release, duplicate code, byte switch while held, unmatched code.
    for (int j = 0; j < 28; j++) begin
      step(tbl[j].st, tbl[j].b, 1'b0);
      check($sformatf("tbl%0d_keys", j), 32'(keys), 32'(tbl[j].ek));
      check($sformatf("tbl%0d_any", j), 32'(any_key), 32'(tbl[j].ea));
    end

    // Repeat key 8'h75 held 30 cycles: pulses at 2, 12, 16, 20, 24, 28 only.
    for (int n = 0; n < 41; n++) begin
      step(n < 30, 8'h75, 1'b0);
      exp_k = (n == 2 || n == 12 || n == 16 || n == 20 || n == 24 || n == 28) ? 6'h08 : 6'h00;
      check($sformatf("rep_n%0d", n), 32'(keys), 32'(exp_k));
    end

    // 8'h75 then 8'h72 while held, reset mid-REPEAT, key held through reset release.
    for (int n = 0; n < 51; n++) begin
      step(n < 38, (n < 15) ? 8'h75 : 8'h72, (n == 32 || n == 33));
      exp_k = 6'h00;
      if (n == 2 || n == 12 || n == 16) exp_k = 6'h08;
      if (n == 17 || n == 27 || n == 31 || n == 36) exp_k = 6'h10;
      check($sformatf("switch_n%0d", n), 32'(keys), 32'(exp_k));
    end

`ifdef KEYDEC_EVENT_LATCH_EN
    do_reset();
    step(1'b1, 8'h43, 1'b0);
    step(1'b1, 8'h43, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("ev_first_valid", 32'(ev_valid), 32'h1);
    check("ev_first_code", 32'(ev_code), 32'h43);
    check("ev_first_ovf", 32'(ev_overflow), 32'h0);
    step(1'b1, 8'h1D, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("ev_drop_valid", 32'(ev_valid), 32'h1);
    check("ev_drop_code", 32'(ev_code), 32'h43);
    check("ev_drop_ovf", 32'(ev_overflow), 32'h1);
    step(1'b1, 8'h29, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    ev_ack = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    check("ev_ackpress_valid", 32'(ev_valid), 32'h1);
    check("ev_ackpress_code", 32'(ev_code), 32'h29);
    step(1'b0, 8'h00, 1'b0);
    ev_ack = 1'b0;
    check("ev_ack_valid", 32'(ev_valid), 32'h0);
    check("ev_sticky_ovf", 32'(ev_overflow), 32'h1);
    step(1'b0, 8'h00, 1'b1);
    check("ev_rst_ovf", 32'(ev_overflow), 32'h0);
    check("ev_rst_code", 32'(ev_code), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
